// File: rtl/imem_dual_fetch_pkg.sv
// ---------------------------------------------------------------------------
// imem_dual_fetch_pkg
//   Shared geometry and types for the dual-line instruction memory.
//   A fetch line is SLOTS instruction slots of DATA_W bits. Slot 0 (the
//   "slot 1" output) sits in the most significant bits of the line.
// ---------------------------------------------------------------------------
package imem_dual_fetch_pkg;

    localparam int unsigned DATA_W = 48;
    localparam int unsigned SLOTS  = 5;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LINE_W = DATA_W * SLOTS;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [DATA_W-1:0] slot_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Extract slot idx (0-based, 0 = most significant field) from a line.
    function automatic slot_t line_slot(input line_t line, input int unsigned idx);
        return line[LINE_W - 1 - idx * DATA_W -: DATA_W];
    endfunction

endpackage

// File: rtl/imem_dual_fetch_sram.sv
// ---------------------------------------------------------------------------
// imem_sram
//   DEPTH x LINE_W synchronous memory with one write port and two registered
//   read ports. The array itself is never reset; only the read registers are
//   cleared by the synchronous active-low reset, which also blocks writes.
//
//   clk      in   clock, all updates on rising edge
//   rst_n    in   synchronous active-low clear of the read registers
//   we       in   write enable
//   waddr    in   write line address
//   wdata    in   write line data
//   re       in   read enable; read registers hold when low
//   raddr_a  in   read address, port A
//   raddr_b  in   read address, port B
//   rdata_a  out  registered read data, port A
//   rdata_b  out  registered read data, port B
// ---------------------------------------------------------------------------
module imem_sram
    import imem_dual_fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  we,
    input  addr_t waddr,
    input  line_t wdata,
    input  logic  re,
    input  addr_t raddr_a,
    input  addr_t raddr_b,
    output line_t rdata_a,
    output line_t rdata_b
);

    // Name kept so loaders can reach it as <top>.i_mem.Register.
    line_t Register [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (we) begin
                Register[waddr] <= wdata;
            end
            if (re) begin
                rdata_a <= Register[raddr_a];
                rdata_b <= Register[raddr_b];
            end
        end
    end

endmodule

// File: rtl/imem_dual_fetch.sv
// ---------------------------------------------------------------------------
// imem_dual_fetch
//   Instruction-fetch memory presenting two consecutive lines (A, A+1) per
//   cycle as ten registered slot outputs. A loader write stalls fetching for
//   that cycle: pointer and outputs hold.
//
//   clock                     in   clock, rising edge
//   reset                     in   synchronous active-low reset
//   WEPin                     in   loader write enable
//   WEAddress                 in   loader line address
//   idataWrite                in   loader line data (slot 1 in MSBs)
//   topmem_out_iMem_data1_k   out  slot k of line A     (k = 1..5)
//   topmem_out_iMem_data2_k   out  slot k of line A + 1 (k = 1..5)
// ---------------------------------------------------------------------------
module imem_dual_fetch
    import imem_dual_fetch_pkg::*;
#(
    parameter int unsigned FETCH_STEP = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              WEPin,
    input  logic [ADDR_W-1:0] WEAddress,
    input  logic [LINE_W-1:0] idataWrite,
    output logic [DATA_W-1:0] topmem_out_iMem_data1_1,
    output logic [DATA_W-1:0] topmem_out_iMem_data1_2,
    output logic [DATA_W-1:0] topmem_out_iMem_data1_3,
    output logic [DATA_W-1:0] topmem_out_iMem_data1_4,
    output logic [DATA_W-1:0] topmem_out_iMem_data1_5,
    output logic [DATA_W-1:0] topmem_out_iMem_data2_1,
    output logic [DATA_W-1:0] topmem_out_iMem_data2_2,
    output logic [DATA_W-1:0] topmem_out_iMem_data2_3,
    output logic [DATA_W-1:0] topmem_out_iMem_data2_4,
    output logic [DATA_W-1:0] topmem_out_iMem_data2_5
);

    addr_t fetch_ptr;
    addr_t fetch_ptr_next_line;
    logic  fetch_en;
    line_t line_a;
    line_t line_b;
    slot_t slots_a [SLOTS];
    slot_t slots_b [SLOTS];

    // Reads are suppressed on write cycles, so read/write never collide.
    assign fetch_en            = ~WEPin;
    assign fetch_ptr_next_line = fetch_ptr + addr_t'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_ptr <= '0;
        end else if (fetch_en) begin
            fetch_ptr <= fetch_ptr + addr_t'(FETCH_STEP);
        end
    end

    imem_sram i_mem (
        .clk     (clock),
        .rst_n   (reset),
        .we      (WEPin),
        .waddr   (WEAddress),
        .wdata   (idataWrite),
        .re      (fetch_en),
        .raddr_a (fetch_ptr),
        .raddr_b (fetch_ptr_next_line),
        .rdata_a (line_a),
        .rdata_b (line_b)
    );

    always_comb begin
        for (int unsigned k = 0; k < SLOTS; k++) begin
            slots_a[k] = line_slot(line_a, k);
            slots_b[k] = line_slot(line_b, k);
        end
    end

    assign topmem_out_iMem_data1_1 = slots_a[0];
    assign topmem_out_iMem_data1_2 = slots_a[1];
    assign topmem_out_iMem_data1_3 = slots_a[2];
    assign topmem_out_iMem_data1_4 = slots_a[3];
    assign topmem_out_iMem_data1_5 = slots_a[4];
    assign topmem_out_iMem_data2_1 = slots_b[0];
    assign topmem_out_iMem_data2_2 = slots_b[1];
    assign topmem_out_iMem_data2_3 = slots_b[2];
    assign topmem_out_iMem_data2_4 = slots_b[3];
    assign topmem_out_iMem_data2_5 = slots_b[4];

endmodule

// File: tb/tb_imem_dual_fetch.sv
// ---------------------------------------------------------------------------
// tb_imem_dual_fetch
//   Directed bench for imem_dual_fetch. Memory is filled through the loader
//   port; line n holds a pattern tagging each slot with its slot number and n.
// ---------------------------------------------------------------------------
module tb_imem_dual_fetch;
    import imem_dual_fetch_pkg::*;

    logic  clock = 1'b0;
    logic  reset;
    logic  WEPin;
    addr_t WEAddress;
    line_t idataWrite;
    slot_t d1_1, d1_2, d1_3, d1_4, d1_5;
    slot_t d2_1, d2_2, d2_3, d2_4, d2_5;
    line_t got1, got2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clock = ~clock;

    imem_dual_fetch #(.FETCH_STEP(2)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .WEPin                   (WEPin),
        .WEAddress               (WEAddress),
        .idataWrite              (idataWrite),
        .topmem_out_iMem_data1_1 (d1_1),
        .topmem_out_iMem_data1_2 (d1_2),
        .topmem_out_iMem_data1_3 (d1_3),
        .topmem_out_iMem_data1_4 (d1_4),
        .topmem_out_iMem_data1_5 (d1_5),
        .topmem_out_iMem_data2_1 (d2_1),
        .topmem_out_iMem_data2_2 (d2_2),
        .topmem_out_iMem_data2_3 (d2_3),
        .topmem_out_iMem_data2_4 (d2_4),
        .topmem_out_iMem_data2_5 (d2_5)
    );

    // Slot 1 is the most significant field, so concatenating outputs 1..5
    // must reproduce the stored line exactly.
    assign got1 = {d1_1, d1_2, d1_3, d1_4, d1_5};
    assign got2 = {d2_1, d2_2, d2_3, d2_4, d2_5};

    function automatic line_t line_val(input int unsigned n);
        line_t l;
        l = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            l[LINE_W - 1 - k * DATA_W -: DATA_W] = {8'(k + 1), 16'(n), 16'hC0DE, 8'(n)};
        end
        return l;
    endfunction

    task automatic check(input string name, input line_t got, input line_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, sample on the falling edge.
    task automatic step(input logic rst, input logic we, input addr_t a, input line_t d);
        reset      = rst;
        WEPin      = we;
        WEAddress  = a;
        idataWrite = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        string name;
        logic  rst;
        logic  we;
        addr_t waddr;
        line_t wdata;
        line_t exp1;
        line_t exp2;
    } vec_t;

    vec_t  tbl [10];
    line_t new6;
    line_t junk;
    line_t new4;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "timeout");
    end

    initial begin
        new6 = {48'h0000_0000_0001, 48'h0000_0000_0002, 48'h0000_0000_0003,
                48'h0000_0000_0004, 48'h0000_0000_ABCD};
        junk = {5{48'hDEAD_BEEF_F00D}};
        new4 = {48'h4444_0000_0001, 48'h4444_0000_0002, 48'h4444_0000_0003,
                48'h4444_0000_0004, 48'h4444_0000_0005};

        // name, rst, we, waddr, wdata, expected line A, expected line A+1
        tbl[0] = '{"seq_0_1",     1'b1, 1'b0, 8'd0, '0,   line_val(0), line_val(1)};
        tbl[1] = '{"seq_2_3",     1'b1, 1'b0, 8'd0, '0,   line_val(2), line_val(3)};
        tbl[2] = '{"seq_4_5",     1'b1, 1'b0, 8'd0, '0,   line_val(4), line_val(5)};
        tbl[3] = '{"write_hold",  1'b1, 1'b1, 8'd6, new6, line_val(4), line_val(5)};
        tbl[4] = '{"after_write", 1'b1, 1'b0, 8'd0, '0,   new6,        line_val(7)};
        tbl[5] = '{"seq_8_9",     1'b1, 1'b0, 8'd0, '0,   line_val(8), line_val(9)};
        tbl[6] = '{"reset_mid",   1'b0, 1'b0, 8'd0, '0,   '0,          '0};
        tbl[7] = '{"reset_wr",    1'b0, 1'b1, 8'd0, junk, '0,          '0};
        tbl[8] = '{"restart_0_1", 1'b1, 1'b0, 8'd0, '0,   line_val(0), line_val(1)};
        tbl[9] = '{"restart_2_3", 1'b1, 1'b0, 8'd0, '0,   line_val(2), line_val(3)};

        // Reset with no memory contents yet: outputs must be zero.
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        check("reset_d1", got1, '0);
        check("reset_d2", got2, '0);

        // Fill memory through the loader port; outputs must hold at zero.
        for (int unsigned n = 0; n < DEPTH; n++) begin
            step(1'b1, 1'b1, addr_t'(n), line_val(n));
        end
        check("load_hold_d1", got1, '0);
        check("load_hold_d2", got2, '0);

        // Reset again with memory preloaded.
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        check("reset2_d1", got1, '0);
        check("reset2_d2", got2, '0);

        for (int unsigned i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].waddr, tbl[i].wdata);
            check({tbl[i].name, "_d1"}, got1, tbl[i].exp1);
            check({tbl[i].name, "_d2"}, got2, tbl[i].exp2);
        end

        // Write latency: write line 4 at pointer 4, next read sees it.
        step(1'b1, 1'b1, 8'd4, new4);
        check("wlat_hold_d1", got1, line_val(2));
        step(1'b1, 1'b0, '0, '0);
        check("wlat_d1", got1, new4);
        check("wlat_d2", got2, line_val(5));

        // Wrap-around over a full pass from reset.
        step(1'b0, 1'b0, '0, '0);
        for (int unsigned c = 1; c <= 129; c++) begin
            step(1'b1, 1'b0, '0, '0);
            if (c == 4) begin
                check("wrap_c4_d1", got1, new6);
                check("wrap_c4_d2", got2, line_val(7));
            end
            if (c == 128) begin
                check("wrap_254_d1", got1, line_val(254));
                check("wrap_255_d2", got2, line_val(255));
            end
            if (c == 129) begin
                check("wrap_0_d1", got1, new4 == '0 ? '0 : line_val(0));
                check("wrap_1_d2", got2, line_val(1));
            end
        end

        // Reset with the pointer at 40.
        step(1'b0, 1'b0, '0, '0);
        for (int unsigned c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, '0, '0);
        end
        check("pre_rst40_d1", got1, line_val(38));
        step(1'b0, 1'b0, '0, '0);
        check("rst40_d1", got1, '0);
        check("rst40_d2", got2, '0);
        step(1'b1, 1'b0, '0, '0);
        check("rst40_rel_d1", got1, line_val(0));
        check("rst40_rel_d2", got2, line_val(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
